// File: rtl/led_blink_ctrl_pkg.sv
// rtl/led_blink_ctrl_pkg.sv - shared state and owner encodings for the LED controller
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam logic [1:0] OWN_HB  = 2'd0;
    localparam logic [1:0] OWN_SEQ = 2'd1;
    localparam logic [1:0] OWN_MCU = 2'd2;

endpackage

// File: rtl/led_blink_ctrl_if.sv
// rtl/led_blink_ctrl_if.sv - blink command handshake bundle
interface led_blink_ctrl_if #(
    parameter int CNT_W  = 8,
    parameter int TIME_W = 16
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CNT_W-1:0]  cmd_count;
    logic [TIME_W-1:0] cmd_on;
    logic [TIME_W-1:0] cmd_off;

    modport master (output cmd_valid, output cmd_count, output cmd_on, output cmd_off,
                    input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_count, input  cmd_on, input  cmd_off,
                    output cmd_ready);
endinterface

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - timing tick prescaler with clear and hold
module led_tick_gen #(
    parameter int TICK_DIV = 25000
) (
    input  logic clk25,
    input  logic fpga_rst_n,
    input  logic clr,
    input  logic hold,
    output logic tick
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;

    // Count 0..TICK_DIV-1; clear restarts phase alignment, hold freezes everything
    always_comb begin
        pre_d = pre_q;
        tick  = (pre_q == LAST) && !hold;
        if (clr) begin
            pre_d = '0;
        end else if (!hold) begin
            pre_d = (pre_q == LAST) ? '0 : pre_q + PW'(1);
        end
    end

    // Prescaler register
    always_ff @(posedge clk25) begin
        if (!fpga_rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
endmodule

// File: rtl/led_blink_ctrl.sv
// rtl/led_blink_ctrl.sv - LED arbiter (MCU > sequencer > heartbeat); optional LED_PAUSE_EN
module led_blink_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 25000,
    parameter int TIME_W   = 16,
    parameter int CNT_W    = 8,
    parameter int HB_W     = 25
) (
    input  logic             clk25,
    input  logic             fpga_rst_n,
    led_blink_ctrl_if.slave  cmd,
    input  logic             mcu_led_out,
    input  logic             mcu_led_oe_n,
    output logic             led,
    output logic [1:0]       owner,
    output logic             busy,
    output logic             done
);
    state_t            state_q, state_d;
    logic [TIME_W-1:0] timer_q, timer_d;
    logic [TIME_W-1:0] on_len_q, on_len_d;
    logic [TIME_W-1:0] off_len_q, off_len_d;
    logic [CNT_W-1:0]  remain_q, remain_d;
    logic              done_q, done_d;
    logic              led_q, led_d;
    logic [1:0]        owner_q, owner_d;
    logic [HB_W-1:0]   hb_q, hb_d;

    logic accept;
    logic tick;
    logic pause;
    logic seq_led;

    assign busy          = (state_q != ST_IDLE);
    assign cmd.cmd_ready = (state_q == ST_IDLE);
    assign accept        = cmd.cmd_valid && (state_q == ST_IDLE);
    assign seq_led       = (state_q == ST_ON);
    assign done          = done_q;
    assign led           = led_q;
    assign owner         = owner_q;

`ifdef LED_PAUSE_EN
    assign pause = busy && !mcu_led_oe_n;
`else
    assign pause = 1'b0;
`endif

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk25      (clk25),
        .fpga_rst_n (fpga_rst_n),
        .clr        (accept),
        .hold       (pause),
        .tick       (tick)
    );

    // Sequencer next state: latch command at accept, step phases on ticks
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        on_len_d  = on_len_q;
        off_len_d = off_len_q;
        remain_d  = remain_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    on_len_d  = (cmd.cmd_on  == '0) ? TIME_W'(1) : cmd.cmd_on;
                    off_len_d = (cmd.cmd_off == '0) ? TIME_W'(1) : cmd.cmd_off;
                    timer_d   = '0;
                    remain_d  = cmd.cmd_count;
                    if (cmd.cmd_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_ON;
                    end
                end
            end
            ST_ON: begin
                if (tick) begin
                    if (timer_q == on_len_q - TIME_W'(1)) begin
                        state_d = ST_OFF;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TIME_W'(1);
                    end
                end
            end
            ST_OFF: begin
                if (tick) begin
                    if (timer_q == off_len_q - TIME_W'(1)) begin
                        timer_d = '0;
                        if (remain_q == CNT_W'(1)) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            remain_d = remain_q - CNT_W'(1);
                            state_d  = ST_ON;
                        end
                    end else begin
                        timer_d = timer_q + TIME_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ownership mux and free-running heartbeat
    always_comb begin
        hb_d = hb_q + HB_W'(1);
        if (!mcu_led_oe_n) begin
            owner_d = OWN_MCU;
            led_d   = mcu_led_out;
        end else if (busy) begin
            owner_d = OWN_SEQ;
            led_d   = seq_led;
        end else begin
            owner_d = OWN_HB;
            led_d   = hb_q[HB_W-1];
        end
    end

    // State and output registers
    always_ff @(posedge clk25) begin
        if (!fpga_rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            on_len_q  <= '0;
            off_len_q <= '0;
            remain_q  <= '0;
            done_q    <= 1'b0;
            led_q     <= 1'b0;
            owner_q   <= OWN_HB;
            hb_q      <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            on_len_q  <= on_len_d;
            off_len_q <= off_len_d;
            remain_q  <= remain_d;
            done_q    <= done_d;
            led_q     <= led_d;
            owner_q   <= owner_d;
            hb_q      <= hb_d;
        end
    end
endmodule

// File: tb/tb_led_blink_ctrl.sv
// tb/tb_led_blink_ctrl.sv - randomized self-checking bench for led_blink_ctrl
module tb_led_blink_ctrl;
    localparam int TD  = 4;
    localparam int HBW = 4;
    localparam int TW  = 16;
    localparam int CW  = 8;
`ifdef LED_PAUSE_EN
    localparam int PAUSE = 1;
`else
    localparam int PAUSE = 0;
`endif

    logic       clk25 = 1'b0;
    logic       fpga_rst_n = 1'b0;
    logic       mcu_led_out = 1'b0;
    logic       mcu_led_oe_n = 1'b1;
    logic       led;
    logic [1:0] owner;
    logic       busy;
    logic       done;

    led_blink_ctrl_if #(.CNT_W(CW), .TIME_W(TW)) cmd_if ();

    led_blink_ctrl #(.TICK_DIV(TD), .TIME_W(TW), .CNT_W(CW), .HB_W(HBW)) dut (
        .clk25        (clk25),
        .fpga_rst_n   (fpga_rst_n),
        .cmd          (cmd_if),
        .mcu_led_out  (mcu_led_out),
        .mcu_led_oe_n (mcu_led_oe_n),
        .led          (led),
        .owner        (owner),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk25 = ~clk25;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int mx1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // Reference model: progress counter through count periods of (on+off)*TD cycles
    bit   m_vld = 0;
    bit   m_busy = 0;
    bit   m_done = 0;
    bit   m_led = 0;
    int   m_owner = 0;
    int   m_k = 0;
    int   m_onc = 1;
    int   m_p = 1;
    int   m_total = 0;
    int   m_hb = 0;
    int   cyc = 0;

    always @(posedge clk25) begin
        cyc <= cyc + 1;
        m_vld <= 1'b1;
        if (!fpga_rst_n) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_led   <= 1'b0;
            m_owner <= 0;
            m_k     <= 0;
            m_hb    <= 0;
        end else begin
            m_hb <= (m_hb + 1) % (1 << HBW);
            if (!mcu_led_oe_n) begin
                m_owner <= 2;
                m_led   <= mcu_led_out;
            end else if (m_busy) begin
                m_owner <= 1;
                m_led   <= ((m_k % m_p) < m_onc);
            end else begin
                m_owner <= 0;
                m_led   <= m_hb[HBW-1];
            end
            m_done <= 1'b0;
            if (m_busy) begin
                if (!(PAUSE != 0 && !mcu_led_oe_n)) begin
                    if (m_k + 1 == m_total) begin
                        m_busy <= 1'b0;
                        m_done <= 1'b1;
                    end
                    m_k <= m_k + 1;
                end
            end else if (cmd_if.cmd_valid) begin
                if (cmd_if.cmd_count == '0) begin
                    m_done <= 1'b1;
                end else begin
                    m_busy  <= 1'b1;
                    m_k     <= 0;
                    m_onc   <= mx1(int'(cmd_if.cmd_on)) * TD;
                    m_p     <= (mx1(int'(cmd_if.cmd_on)) + mx1(int'(cmd_if.cmd_off))) * TD;
                    m_total <= int'(cmd_if.cmd_count) *
                               (mx1(int'(cmd_if.cmd_on)) + mx1(int'(cmd_if.cmd_off))) * TD;
                end
            end
        end
    end

    int busy_cycles = 0;
    int done_pulses = 0;
    int last_done_cyc = 0;

    // Compare every output against the model away from the active edge
    always @(negedge clk25) begin
        if (m_vld) begin
            check("led", led, m_led);
            check("owner", owner, m_owner);
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("cmd_ready", cmd_if.cmd_ready, !m_busy);
        end
        if (busy) busy_cycles <= busy_cycles + 1;
        if (done) begin
            done_pulses   <= done_pulses + 1;
            last_done_cyc <= cyc;
        end
    end

    int acc_cyc = 0;
    bit rnd_oe = 0;

    task automatic step();
        @(posedge clk25);
        #1;
        if (rnd_oe) begin
            mcu_led_oe_n = ($urandom_range(0, 9) != 0);
            mcu_led_out  = $urandom_range(0, 1);
        end
    endtask

    task automatic send(input int cnt, input int on, input int off);
        for (int i = 0; i < 2000 && !cmd_if.cmd_ready; i++) step();
        check("send_ready", cmd_if.cmd_ready, 1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_count = CW'(cnt);
        cmd_if.cmd_on    = TW'(on);
        cmd_if.cmd_off   = TW'(off);
        step();
        acc_cyc = cyc;
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && busy; i++) step();
        check("idle_timeout", busy, 0);
    endtask

    int b0, d0;

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_count = '0;
        cmd_if.cmd_on    = '0;
        cmd_if.cmd_off   = '0;
        repeat (3) step();
        fpga_rst_n = 1'b1;
        repeat (40) step();

        // Basic two-blink sequence
        b0 = busy_cycles;
        d0 = done_pulses;
        send(2, 3, 2);
        wait_idle();
        repeat (2) step();
        check("busy_len", busy_cycles - b0, 40);
        check("done_pulses", done_pulses - d0, 1);
        check("done_cycle", last_done_cyc, acc_cyc + 40);

        // Null command
        d0 = done_pulses;
        send(0, 5, 0);
        repeat (3) step();
        check("null_done", done_pulses - d0, 1);

        // MCU takeover mid-sequence
        send(2, 3, 2);
        repeat (15) step();
        mcu_led_out  = 1'b1;
        mcu_led_oe_n = 1'b0;
        repeat (10) step();
        mcu_led_oe_n = 1'b1;
        mcu_led_out  = 1'b0;
        wait_idle();
        repeat (2) step();
        check("takeover_done", last_done_cyc, acc_cyc + 40 + PAUSE * 10);

        // Reset during ON
        d0 = done_pulses;
        send(3, 4, 4);
        repeat (5) step();
        fpga_rst_n = 1'b0;
        step();
        fpga_rst_n = 1'b1;
        repeat (20) step();
        check("rst_no_done", done_pulses - d0, 0);

        // cmd_valid held across sequences
        d0 = done_pulses;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_count = CW'(1);
        cmd_if.cmd_on    = TW'(2);
        cmd_if.cmd_off   = TW'(1);
        repeat (30) step();
        cmd_if.cmd_valid = 1'b0;
        wait_idle();
        repeat (2) step();
        check("held_valid_dones", done_pulses - d0, 3);

        // Randomized commands with random MCU interference
        for (int n = 0; n < 30; n++) begin
            rnd_oe = ($urandom_range(0, 2) == 0);
            send($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            repeat ($urandom_range(0, 6)) step();
            wait_idle();
            rnd_oe = 1'b0;
            mcu_led_oe_n = 1'b1;
            repeat ($urandom_range(0, 3)) step();
        end
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/led_blink_ctrl.md
Name: led_blink_ctrl

Overview:
- Controller and arbiter for the single board LED pin, clocked on clk25.
- Three sources compete for the pin:
  - the MCU GPIO path (gpio_h0_out with its active-low enable);
  - a command-driven blink sequencer (N pulses with programmable on/off times, valid/ready handshake);
  - a free-running fabric heartbeat.
- Fixed priority: MCU > sequencer > heartbeat. Replaces the bare counter-bit LED drive at top level.

Parameters:
- TICK_DIV, 25000: clk25 cycles per timing tick (1 ms at 25 MHz); must be ≥ 2.
- TIME_W, 16: width of on/off durations, in ticks.
- CNT_W, 8: width of the blink count.
- HB_W, 25: heartbeat counter width; heartbeat LED = counter MSB.

Ports:
- clk25  in  1  system clock from the PLL.
- fpga_rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  blink command request.
- cmd_ready  out  1  high when the sequencer can accept a command (state IDLE).
- cmd_count  in  CNT_W  number of blinks; 0 means a null command.
- cmd_on  in  TIME_W  on time in ticks; 0 is treated as 1.
- cmd_off  in  TIME_W  off time in ticks; 0 is treated as 1.
- mcu_led_out  in  1  MCU GPIO output value.
- mcu_led_oe_n  in  1  MCU output enable, active-low; 0 means the MCU owns the LED.
- led  out  1  registered LED drive.
- owner  out  2  registered owner code: 0 heartbeat, 1 sequencer, 2 MCU.
- busy  out  1  sequencer active (state not IDLE).
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Clock and reset: one clock (clk25); fpga_rst_n is synchronous and active-low.
- Reset values: state IDLE, led=0, owner=0, busy=0, done=0, cmd_ready=1 from the first clock after reset releases. Heartbeat counter, prescaler, timer and remaining count all cleared.
- Reset mid-operation: the sequence is aborted on the next edge, no done pulse is produced, and the command is not resumed.
- Handshake:
  - A command is accepted on the edge where cmd_valid && cmd_ready.
  - cmd_count, on_len = max(cmd_on,1) and off_len = max(cmd_off,1) are latched at accept.
  - cmd_ready is combinational: (state==IDLE).
- Prescaler:
  - Counts 0..TICK_DIV-1 and emits tick on TICK_DIV-1, then wraps to 0.
  - Cleared on command accept, so every phase lasts an exact multiple of TICK_DIV cycles.
- FSM:
  - IDLE: on accept with count≠0, go to ON (timer=0, remaining=count). On accept with count=0, stay IDLE and pulse done on the next cycle.
  - ON: seq_led=1. On a tick, if timer==on_len-1 go to OFF with timer=0; otherwise timer++.
  - OFF: seq_led=0. On a tick, if timer==off_len-1:
    - if remaining==1, go to IDLE and assert done in the cycle state becomes IDLE;
    - otherwise remaining-- and go to ON.
    Otherwise timer++.
- Timing: state ON begins the cycle after accept. Total busy time = count×(on_len+off_len)×TICK_DIV cycles.
- Back-to-back commands: a new command may be accepted in the done cycle.
- Arbitration, evaluated each cycle and registered (1-cycle latency):
  - mcu_led_oe_n==0: owner=2, led=mcu_led_out.
  - else if busy: owner=1, led=seq_led.
  - else: owner=0, led=hb_cnt[HB_W-1].
- Heartbeat: the counter free-runs and wraps at 2^HB_W; it is unaffected by ownership.
- MCU takeover without the optional feature: the sequencer keeps running, shadowed, and done timing is unchanged.
- Counters wrap silently. Blink count has no overflow because remaining only decrements.

Optional Feature:
- Macro LED_PAUSE_EN. When defined: while busy && mcu_led_oe_n==0, the prescaler, timer and FSM hold. done is delayed by exactly the number of cycles the MCU owned the LED during the command.
- When undefined: no pause; the sequencer runs independently of ownership.

Decomposition:
- Package led_ctrl_pkg holds:
  - the state enum (ST_IDLE, ST_ON, ST_OFF);
  - owner codes OWN_HB=2'd0, OWN_SEQ=2'd1, OWN_MCU=2'd2.
- One sub-module, led_tick_gen: the prescaler, with inputs clr and hold and output tick.
- FSM, arbitration mux and heartbeat stay in the top module.

Test Plan (TICK_DIV=4, HB_W=4):
- Reset, idle, oe_n=1 -> led=0, owner=0, cmd_ready=1 after release; then led alternates in 8-cycle low/high runs.
- Accept count=2, on=3, off=2 -> owner=1; led high 12, low 8, high 12, low 8 cycles; busy high for 40 cycles; exactly one done pulse; cmd_ready=1 in the done cycle.
- count=0, on=5 -> accepted, busy stays 0, done pulses on the next cycle; owner stays 0.
- Mid-sequence oe_n=0 for 10 cycles with mcu_led_out=1 -> owner=2, led=1 one cycle later. Without LED_PAUSE_EN, done at the same cycle as the undisturbed run; with it, done 10 cycles later.
- Reset asserted during ON -> next cycle busy=0, led=0, owner=0; no done pulse.
- cmd_valid held high across a sequence -> not accepted while busy; second command accepted in the done cycle, and the next ON starts the following cycle.
